// File: rtl/ws2812_pkg.sv
// Shared types and device timing defaults for the multi-channel WS281x serializer.
package ws2812_pkg;

  typedef enum logic [1:0] {StLatch, StIdle, StLoad, StBit} state_e;

  localparam int unsigned BITS_RGB  = 24;
  localparam int unsigned BITS_RGBW = 32;

  // WS2812B at 50 MHz: 0.42 / 0.84 us high, 1.26 us symbol, 52 us latch.
  localparam int unsigned Ws2812bCycles0High = 21;
  localparam int unsigned Ws2812bCycles1High = 42;
  localparam int unsigned Ws2812bCyclesBit   = 63;
  localparam int unsigned Ws2812bCyclesReset = 2600;

  // SK6812 at 50 MHz: 0.3 / 0.6 us high, 1.26 us symbol, 80 us latch.
  localparam int unsigned Sk6812Cycles0High = 15;
  localparam int unsigned Sk6812Cycles1High = 30;
  localparam int unsigned Sk6812CyclesBit   = 63;
  localparam int unsigned Sk6812CyclesReset = 4000;

endpackage

// File: rtl/ws2812_symbol_timer.sv
// Shared phase counter: times each symbol and the latch gap for all channels at once.
module ws2812_symbol_timer #(
  parameter int unsigned CYCLES_BIT   = 63,
  parameter int unsigned CYCLES_RESET = 2600,
  parameter int unsigned PhaseW       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic [PhaseW-1:0] phase,
  output logic              bit_end,
  output logic              latch_end
);

  logic [PhaseW-1:0] phase_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (clr) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PhaseW'(1);
    end
  end

  assign phase     = phase_q;
  assign bit_end   = (phase_q == PhaseW'(CYCLES_BIT - 1));
  assign latch_end = (phase_q == PhaseW'(CYCLES_RESET - 1));

endmodule

// File: rtl/ws2812_multi.sv
// Lock-step WS281x serializer: one symbol timer, CHANNELS shift registers, one pixel index.
module ws2812_multi
  import ws2812_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned LED_COUNT     = 144,
  parameter int unsigned BITS_PER_LED  = BITS_RGB,
  parameter int unsigned REVERSE       = 0,
  parameter int unsigned CONTINUOUS    = 0,
  parameter int unsigned CYCLES_0_HIGH = Ws2812bCycles0High,
  parameter int unsigned CYCLES_1_HIGH = Ws2812bCycles1High,
  parameter int unsigned CYCLES_BIT    = Ws2812bCyclesBit,
  parameter int unsigned CYCLES_RESET  = Ws2812bCyclesReset,
  localparam int unsigned AW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  output logic [AW-1:0]                    address_o,
  input  logic [CHANNELS*BITS_PER_LED-1:0] pix_i,
  output logic [CHANNELS-1:0]              data_o,
  output logic                             busy_o,
  output logic                             frame_done_o
);

  localparam int unsigned PhaseMax = (CYCLES_BIT > CYCLES_RESET) ? CYCLES_BIT : CYCLES_RESET;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned BitCntW  = $clog2(BITS_PER_LED);
  localparam logic [AW-1:0] FirstIdx = (REVERSE != 0) ? AW'(LED_COUNT - 1) : '0;
  localparam logic [AW-1:0] LastIdx  = (REVERSE != 0) ? '0 : AW'(LED_COUNT - 1);

  if (!(CYCLES_0_HIGH < CYCLES_1_HIGH && CYCLES_1_HIGH < CYCLES_BIT)) begin : gen_bad_timing
    $error("ws2812_multi: need CYCLES_0_HIGH < CYCLES_1_HIGH < CYCLES_BIT");
  end
  if (BITS_PER_LED != BITS_RGB && BITS_PER_LED != BITS_RGBW) begin : gen_bad_width
    $error("ws2812_multi: BITS_PER_LED must be 24 or 32");
  end
  if (LED_COUNT < 1 || CYCLES_RESET < 1) begin : gen_bad_count
    $error("ws2812_multi: LED_COUNT and CYCLES_RESET must be at least 1");
  end

  state_e              state_q;
  logic [AW-1:0]       idx_q, idx_next;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic                first_pass_q, done_q, busy_q;
  logic [CHANNELS-1:0] data_q, line_hi;
  logic [PhaseW-1:0]   phase;
  logic                bit_end, latch_end, timer_clr;

  ws2812_symbol_timer #(
    .CYCLES_BIT   (CYCLES_BIT),
    .CYCLES_RESET (CYCLES_RESET),
    .PhaseW       (PhaseW)
  ) u_timer (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clr       (timer_clr),
    .phase     (phase),
    .bit_end   (bit_end),
    .latch_end (latch_end)
  );

  // Phase restarts at every symbol and gap boundary and is held at zero in IDLE/LOAD.
  always_comb begin
    timer_clr = 1'b1;
    case (state_q)
      StLatch: timer_clr = latch_end;
      StBit:   timer_clr = bit_end;
      default: timer_clr = 1'b1;
    endcase
  end

  always_comb begin
    idx_next = idx_q;
    if (idx_q == LastIdx) begin
      idx_next = FirstIdx;
    end else if (REVERSE != 0) begin
      idx_next = idx_q - AW'(1);
    end else begin
      idx_next = idx_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StLatch;
      idx_q        <= FirstIdx;
      bit_cnt_q    <= '0;
      first_pass_q <= 1'b1;
      done_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StLatch: begin
          if (latch_end) begin
            done_q       <= !first_pass_q;
            first_pass_q <= 1'b0;
            if (CONTINUOUS != 0) begin
              state_q <= StLoad;
            end else begin
              state_q <= StIdle;
              // Busy spans the done pulse so it drops the cycle after it.
              busy_q  <= !first_pass_q;
            end
          end
        end
        StIdle: begin
          if (start_i) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        StLoad: begin
          idx_q     <= idx_next;
          bit_cnt_q <= BitCntW'(BITS_PER_LED - 1);
          state_q   <= StBit;
        end
        StBit: begin
          if (bit_end) begin
            if (bit_cnt_q == '0) begin
              // Index already points past the pixel just sent; back at first means done.
              state_q <= (idx_q == FirstIdx) ? StLatch : StLoad;
            end else begin
              bit_cnt_q <= bit_cnt_q - BitCntW'(1);
            end
          end
        end
        default: state_q <= StLatch;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : gen_chan
    logic [BITS_PER_LED-1:0] sreg_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        sreg_q <= '0;
      end else if (state_q == StLoad) begin
        sreg_q <= pix_i[c*BITS_PER_LED +: BITS_PER_LED];
      end else if (state_q == StBit && bit_end) begin
        sreg_q <= {sreg_q[BITS_PER_LED-2:0], 1'b0};
      end
    end

    assign line_hi[c] = (state_q == StBit) &&
                        (phase < (sreg_q[BITS_PER_LED-1] ? PhaseW'(CYCLES_1_HIGH)
                                                         : PhaseW'(CYCLES_0_HIGH)));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= line_hi;
    end
  end

  assign address_o    = idx_q;
  assign data_o       = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_ws2812_multi.sv
// Randomized bench for ws2812_multi: three instances (RGB, reversed RGBW, continuous RGB)
// checked against a waveform model computed from symbol arithmetic.
module tb_ws2812_multi;

  localparam int unsigned T0H = 2;
  localparam int unsigned T1H = 4;
  localparam int unsigned CB  = 6;
  localparam int unsigned CR  = 20;
  localparam int unsigned NA  = 3;
  localparam int unsigned NB  = 3;
  localparam int unsigned NC  = 2;
  localparam int unsigned PC  = 1 + 24 * CB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c, start_a, start_b, start_c;
  logic [1:0]  addr_a, addr_b;
  logic [0:0]  addr_c;
  logic [47:0] pix_a, pix_c;
  logic [31:0] pix_b;
  logic [1:0]  data_a, data_c;
  logic [0:0]  data_b;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

  logic [23:0] mem_a [2][NA];
  logic [31:0] mem_b [NB];
  logic [23:0] mem_c [2][NC];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  ws2812_multi #(
    .CHANNELS(2), .LED_COUNT(NA), .BITS_PER_LED(24), .REVERSE(0), .CONTINUOUS(0),
    .CYCLES_0_HIGH(T0H), .CYCLES_1_HIGH(T1H), .CYCLES_BIT(CB), .CYCLES_RESET(CR)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_a), .start_i(start_a), .address_o(addr_a), .pix_i(pix_a),
    .data_o(data_a), .busy_o(busy_a), .frame_done_o(done_a)
  );

  ws2812_multi #(
    .CHANNELS(1), .LED_COUNT(NB), .BITS_PER_LED(32), .REVERSE(1), .CONTINUOUS(0),
    .CYCLES_0_HIGH(T0H), .CYCLES_1_HIGH(T1H), .CYCLES_BIT(CB), .CYCLES_RESET(CR)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .start_i(start_b), .address_o(addr_b), .pix_i(pix_b),
    .data_o(data_b), .busy_o(busy_b), .frame_done_o(done_b)
  );

  ws2812_multi #(
    .CHANNELS(2), .LED_COUNT(NC), .BITS_PER_LED(24), .REVERSE(0), .CONTINUOUS(1),
    .CYCLES_0_HIGH(T0H), .CYCLES_1_HIGH(T1H), .CYCLES_BIT(CB), .CYCLES_RESET(CR)
  ) dut_c (
    .clk_i(clk), .rst_ni(rst_c), .start_i(start_c), .address_o(addr_c), .pix_i(pix_c),
    .data_o(data_c), .busy_o(busy_c), .frame_done_o(done_c)
  );

  // Frame buffers with one-cycle synchronous read.
  always @(posedge clk) begin
    pix_a <= {mem_a[1][addr_a], mem_a[0][addr_a]};
    pix_b <= mem_b[addr_b];
    pix_c <= {mem_c[1][addr_c], mem_c[0][addr_c]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Line level at offset t into the pixel stream; each pixel is one low LOAD clock
  // followed by MSB-first symbols.
  function automatic logic exp_level(input int unsigned t, input int unsigned bits,
                                     input logic [31:0] word);
    int unsigned r, s, bi, ph;
    r = t % (1 + bits * CB);
    if (r == 0) return 1'b0;
    s  = r - 1;
    bi = s / CB;
    ph = s % CB;
    return ph < (word[bits-1-bi] ? T1H : T0H);
  endfunction

  // Starts a frame on dut_a or dut_b at an IDLE negedge and checks every clock until IDLE.
  task automatic run_frame(input bit is_b, input bit hold);
    int unsigned n, bits, p, fl, k;
    logic [31:0] word;
    logic [1:0]  exp_d, got_d;
    string       pfx;
    pfx  = is_b ? "b" : "a";
    n    = is_b ? NB : NA;
    bits = is_b ? 32 : 24;
    p    = 1 + bits * CB;
    fl   = 1 + n * p + CR;
    check_eq({pfx, "_addr_first"}, is_b ? 32'(addr_b) : 32'(addr_a), is_b ? NB - 1 : 0);
    if (is_b) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 1; c <= int'(fl) + 1; c++) begin
      @(negedge clk);
      if (is_b) start_b = hold && (c < int'(fl) - 3);
      else      start_a = hold && (c < int'(fl) - 3);
      exp_d = '0;
      if (c >= 2 && c - 2 < int'(n * p)) begin
        k = (c - 2) / p;
        for (int ch = 0; ch < (is_b ? 1 : 2); ch++) begin
          word = is_b ? mem_b[NB-1-k] : 32'(mem_a[ch][k]);
          exp_d[ch] = exp_level(c - 2, bits, word);
        end
      end
      got_d = is_b ? {1'b0, data_b} : data_a;
      check_eq({pfx, "_data"}, 32'(got_d), 32'(exp_d));
      check_eq({pfx, "_done"}, is_b ? 32'(done_b) : 32'(done_a), 32'(c == int'(fl)));
      check_eq({pfx, "_busy"}, is_b ? 32'(busy_b) : 32'(busy_a), 32'(c <= int'(fl)));
      if ((c - 1) % p == 0 && c - 1 < int'(n * p)) begin
        k = (c - 1) / p;
        check_eq({pfx, "_addr_seq"}, is_b ? 32'(addr_b) : 32'(addr_a), is_b ? NB - 1 - k : k);
      end
      if (c == int'(fl))
        check_eq({pfx, "_addr_wrap"}, is_b ? 32'(addr_b) : 32'(addr_a), is_b ? NB - 1 : 0);
    end
  endtask

  // Called at the negedge right after the last reset edge.
  task automatic reset_gap_a();
    for (int i = 0; i < int'(CR); i++) begin
      check_eq("a_gap_busy", 32'(busy_a), 1);
      check_eq("a_gap_data", 32'(data_a), 0);
      check_eq("a_gap_done", 32'(done_a), 0);
      @(negedge clk);
    end
    check_eq("a_idle_busy", 32'(busy_a), 0);
    check_eq("a_idle_done", 32'(done_a), 0);
  endtask

  task automatic fill_a_pattern();
    for (int i = 0; i < int'(NA); i++) begin
      mem_a[0][i] = 24'hFF0000;
      mem_a[1][i] = 24'h000001;
    end
  endtask

  task automatic fill_a_random();
    for (int i = 0; i < int'(NA); i++) begin
      mem_a[0][i] = 24'($urandom);
      mem_a[1][i] = 24'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    fill_a_random();
    for (int i = 0; i < int'(NB); i++) mem_b[i] = $urandom;
    for (int i = 0; i < int'(NC); i++) begin
      mem_c[0][i] = 24'($urandom);
      mem_c[1][i] = 24'($urandom);
    end
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    fork
      begin : thr_a
        reset_gap_a();
        fill_a_pattern();
        run_frame(1'b0, 1'b0);
        fill_a_random();
        run_frame(1'b0, 1'b1);
        fill_a_random();
        run_frame(1'b0, 1'b0);
        // Reset while both lines would be driving the high part of a symbol.
        fill_a_pattern();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (13) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check_eq("a_rst_data", 32'(data_a), 0);
        check_eq("a_rst_busy", 32'(busy_a), 1);
        check_eq("a_rst_addr", 32'(addr_a), 0);
        rst_a = 1'b1;
        reset_gap_a();
        fill_a_random();
        run_frame(1'b0, 1'b0);
      end
      begin : thr_b
        repeat (CR) @(negedge clk);
        check_eq("b_idle_busy", 32'(busy_b), 0);
        for (int i = 0; i < int'(NB); i++) mem_b[i] = 32'h80000001;
        run_frame(1'b1, 1'b0);
        for (int i = 0; i < int'(NB); i++) mem_b[i] = $urandom;
        run_frame(1'b1, 1'b1);
      end
      begin : thr_c
        int first_done, second_done;
        logic [1:0] exp_d;
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c < 700; c++) begin
          exp_d = '0;
          if (c >= 21 && c - 21 < int'(NC * PC)) begin
            for (int ch = 0; ch < 2; ch++)
              exp_d[ch] = exp_level(c - 21, 24, 32'(mem_c[ch][(c - 21) / PC]));
            check_eq("c_data", 32'(data_c), 32'(exp_d));
          end
          check_eq("c_busy", 32'(busy_c), 1);
          if (done_c === 1'b1) begin
            if (first_done < 0) first_done = c;
            else if (second_done < 0) second_done = c;
          end
          @(negedge clk);
        end
        check_eq("c_first_done", 32'(first_done), 20 + NC * PC + CR);
        check_eq("c_period", 32'(second_done - first_done), NC * PC + CR);
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
